wasca_spi_stm32_seq: RTL and testbench

//  Transaction sequencer/arbiter in front of the 16-bit STM32 SPI master core. Two requesters
//  (0: CPU mailbox, 1: HW poller) each post an N-word full-duplex burst; block arbitrates

---
 rtl/wasca_spi_stm32_seq.sv | 190 +++++++++++++++++++
 tb/tb_wasca_spi_stm32_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wasca_spi_stm32_seq.sv
// Burst sequencer / round-robin arbiter in front of the 16-bit STM32 SPI master core.
// Two requesters post N-word full-duplex bursts. Each word is one tx write followed by
// one rx read, and SS_n is held low for the whole burst through the control-register SSO bit.
module wasca_spi_stm32_seq #(
    parameter int LEN_W = 8,
    parameter int TMO_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    input  logic [15:0]      tx_data0,
    input  logic [15:0]      tx_data1,
    output logic [1:0]       tx_ack,
    output logic [1:0]       grant,
    output logic [15:0]      rx_data,
    output logic [1:0]       rx_valid,
    output logic [1:0]       done,
    output logic             err,
    output logic             spi_select,
    output logic [2:0]       spi_addr,
    output logic             spi_read_n,
    output logic             spi_write_n,
    output logic [15:0]      spi_wdata,
    input  logic [15:0]      spi_rdata,
    input  logic             spi_trdy,
    input  logic             spi_rrdy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_SSO_ON,
        S_WAIT_T,
        S_WR_TX,
        S_WAIT_R,
        S_RD_RX,
        S_SSO_OFF,
        S_DONE
    } state_t;

    // Last cycle index of a wait state before giving up (2**TMO_W-1 cycles in total).
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;   // core access: 0,1 = bus cycles, 2 = idle gap
    logic               owner_q, owner_d;
    logic               rr_q, rr_d;         // last owner; the other side wins a tie
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic [15:0]        txw_q, txw_d;       // tx word held for the second bus cycle
    logic [15:0]        rx_data_q, rx_data_d;

    logic [15:0]        tx_sel;
    logic               is_access;
    logic               bus_active;

    assign tx_sel     = owner_q ? tx_data1 : tx_data0;
    assign is_access  = (state_q == S_CLR) || (state_q == S_SSO_ON) || (state_q == S_WR_TX) ||
                        (state_q == S_RD_RX) || (state_q == S_SSO_OFF);
    assign bus_active = is_access && (phase_q != 2'd2);

    // State and datapath registers; the core shares this reset, so SS_n releases with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            owner_q   <= 1'b0;
            rr_q      <= 1'b1;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            txw_q     <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            txw_q     <= txw_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Next-state logic: arbitration, access phasing, word count and wait timeouts.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        tmo_d     = '0;
        err_d     = err_q;
        txw_d     = txw_q;
        rx_data_d = rx_data_q;
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (req != 2'b00) begin
                    if (req == 2'b11) owner_d = ~rr_q;
                    else              owner_d = req[1];
                    cnt_d   = owner_d ? req_len1 : req_len0;
                    err_d   = 1'b0;
                    state_d = (cnt_d == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR, S_SSO_ON, S_WR_TX, S_RD_RX, S_SSO_OFF: begin
                phase_d = phase_q + 2'd1;
                if (state_q == S_WR_TX && phase_q == 2'd0) txw_d = tx_sel;
                if (state_q == S_RD_RX && phase_q == 2'd1) rx_data_d = spi_rdata;
                if (phase_q == 2'd2) begin
                    phase_d = '0;
                    if (state_q == S_CLR)         state_d = S_SSO_ON;
                    else if (state_q == S_SSO_ON) state_d = S_WAIT_T;
                    else if (state_q == S_WR_TX)  state_d = S_WAIT_R;
                    else if (state_q == S_RD_RX) begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = (cnt_d == '0) ? S_SSO_OFF : S_WAIT_T;
                    end else                      state_d = S_DONE;
                end
            end
            S_WAIT_T: begin
                if (spi_trdy) begin
                    state_d = S_WR_TX;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_SSO_OFF;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT_R: begin
                // First cycle is ignored: together with the WR_TX gap this gives two
                // idle cycles, so an RRDY left over from before the write cannot alias.
                if (spi_rrdy && tmo_q != '0) begin
                    state_d = S_RD_RX;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_SSO_OFF;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                rr_d    = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Core register port and requester handshakes, decoded from state and phase.
    always_comb begin
        spi_select  = bus_active;
        spi_addr    = 3'd0;
        spi_write_n = 1'b1;
        spi_read_n  = 1'b1;
        spi_wdata   = 16'h0000;
        tx_ack      = 2'b00;
        rx_valid    = 2'b00;
        grant       = 2'b00;
        done        = 2'b00;
        err         = 1'b0;
        if (bus_active) begin
            if (state_q == S_RD_RX) spi_read_n  = 1'b0;
            else                    spi_write_n = 1'b0;
            if (state_q == S_CLR)                                 spi_addr = 3'd2;
            else if (state_q == S_SSO_ON || state_q == S_SSO_OFF) spi_addr = 3'd3;
            else if (state_q == S_WR_TX)                          spi_addr = 3'd1;
            else                                                  spi_addr = 3'd0;
            if (state_q == S_SSO_ON) spi_wdata = 16'h0400;
            if (state_q == S_WR_TX)  spi_wdata = (phase_q == 2'd0) ? tx_sel : txw_q;
        end
        if (state_q == S_WR_TX && phase_q == 2'd0) tx_ack[owner_q]   = 1'b1;
        if (state_q == S_RD_RX && phase_q == 2'd2) rx_valid[owner_q] = 1'b1;
        if (state_q != S_IDLE) grant[owner_q] = 1'b1;
        if (state_q == S_DONE) begin
            done[owner_q] = 1'b1;
            err           = err_q;
        end
    end

    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_wasca_spi_stm32_seq.sv
// Directed bench for wasca_spi_stm32_seq with a small behavioural SPI-core model
// (loopback or MISO stuck at 0, optional RRDY suppression).
module tb_wasca_spi_stm32_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  req_len0 = 8'd0, req_len1 = 8'd0;
    logic [15:0] tx_data0 = 16'h0, tx_data1 = 16'h0;
    logic [1:0]  tx_ack, grant, rx_valid, done;
    logic [15:0] rx_data, spi_wdata, spi_rdata;
    logic        err, spi_select, spi_read_n, spi_write_n;
    logic [2:0]  spi_addr;
    logic        spi_trdy, spi_rrdy;

    wasca_spi_stm32_seq #(.LEN_W(8), .TMO_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_len0(req_len0), .req_len1(req_len1),
        .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ack(tx_ack), .grant(grant),
        .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err),
        .spi_select(spi_select), .spi_addr(spi_addr), .spi_read_n(spi_read_n),
        .spi_write_n(spi_write_n), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_trdy(spi_trdy), .spi_rrdy(spi_rrdy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI core model
    logic        rrdy_block = 1'b0, miso0 = 1'b0;
    logic [15:0] rxreg, shreg;
    logic        sso_m, prev_sel;
    int          cd;
    int          wr_n = 0, sso_tx_n = 0;
    logic [19:0] acc_log [0:255];   // {read, addr, data}

    assign spi_rdata = (spi_addr == 3'd0) ? rxreg : 16'h0000;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_trdy <= 1'b1; spi_rrdy <= 1'b0; rxreg <= '0; shreg <= '0;
            sso_m <= 1'b0; prev_sel <= 1'b0; cd <= 0;
        end else begin
            prev_sel <= spi_select;
            if (spi_select && !prev_sel) begin
                acc_log[wr_n % 256] <= {~spi_read_n, spi_addr, spi_write_n ? 16'h0 : spi_wdata};
                wr_n <= wr_n + 1;
                if (!spi_write_n && spi_addr == 3'd1) begin
                    shreg <= spi_wdata; spi_trdy <= 1'b0; cd <= 8;
                    if (sso_m) sso_tx_n <= sso_tx_n + 1;
                end
                if (!spi_write_n && spi_addr == 3'd2) spi_rrdy <= 1'b0;
                if (!spi_write_n && spi_addr == 3'd3) sso_m <= spi_wdata[10];
                if (!spi_read_n && spi_addr == 3'd0) spi_rrdy <= 1'b0;
            end
            if (cd != 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    spi_trdy <= 1'b1;
                    spi_rrdy <= !rrdy_block;
                    rxreg    <= miso0 ? 16'h0000 : shreg;
                end
            end
        end
    end

    // Requester-side monitor
    int          rx_n = 0, ack_n = 0, ack_cyc = 0;
    logic [15:0] rx_log [0:255];
    logic        rx_own [0:255];
    always @(negedge clk) begin
        if (rx_valid != 2'b00) begin
            rx_log[rx_n % 256] <= rx_data;
            rx_own[rx_n % 256] <= rx_valid[1];
            rx_n <= rx_n + 1;
        end
        if (tx_ack != 2'b00) begin
            ack_n   <= ack_n + 1;
            ack_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int maxc, output logic [1:0] d, output logic e, output int c);
        d = 2'b00; e = 1'b0; c = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                d = done; e = err; c = cyc;
                return;
            end
        end
        chk("done_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    logic [1:0] d;
    logic       e;
    int         c, wb, rb, ab, sb;
    logic [19:0] exp_acc [0:4];
    logic [19:0] msk_acc [0:4];

    initial begin
        // reset values
        #1;
        chk("rst_outs", {grant, tx_ack, rx_valid, done, err, spi_select, spi_read_n, spi_write_n},
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
        chk("rst_bus", {spi_addr, spi_wdata, rx_data}, 35'h0);
        do_reset();

        // single word loopback
        wb = wr_n; rb = rx_n;
        tx_data0 = 16'hA55A; req_len0 = 8'd1; req = 2'b01;
        wait_done(400, d, e, c); req = 2'b00;
        chk("t1_done", d, 2'b01);
        chk("t1_err", e, 1'b0);
        @(negedge clk);
        chk("t1_nacc", wr_n - wb, 5);
        chk("t1_nrx", rx_n - rb, 1);
        chk("t1_rx", rx_log[rb % 256], 16'hA55A);
        exp_acc = '{{1'b0,3'd2,16'h0}, {1'b0,3'd3,16'h0400}, {1'b0,3'd1,16'hA55A},
                    {1'b1,3'd0,16'h0}, {1'b0,3'd3,16'h0000}};
        msk_acc = '{20'hF0000, 20'hFFFFF, 20'hFFFFF, 20'hF0000, 20'hFFFFF};
        for (int i = 0; i < 5; i++)
            chk($sformatf("t1_acc%0d", i), acc_log[(wb + i) % 256] & msk_acc[i], exp_acc[i]);

        // both requesting from reset, len 2 each
        do_reset();
        rb = rx_n;
        tx_data0 = 16'h1111; tx_data1 = 16'h2222; req_len0 = 8'd2; req_len1 = 8'd2; req = 2'b11;
        wait_done(800, d, e, c); req[0] = 1'b0;
        chk("t2_first", d, 2'b01);
        wait_done(800, d, e, c); req = 2'b00;
        chk("t2_second", d, 2'b10);
        @(negedge clk);
        chk("t2_nrx", rx_n - rb, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_rx%0d", i), {rx_own[(rb + i) % 256], rx_log[(rb + i) % 256]},
                (i < 2) ? {1'b0, 16'h1111} : {1'b1, 16'h2222});

        // next tie goes back to requester 0
        req_len0 = 8'd0; req_len1 = 8'd0; req = 2'b11;
        wait_done(50, d, e, c); req = 2'b00;
        chk("tie_owner", d, 2'b01);
        repeat (2) @(negedge clk);

        // zero-length burst: no core access
        wb = wr_n;
        req = 2'b10;
        @(negedge clk);
        chk("t3_grant", grant, 2'b10);
        chk("t3_done", done, 2'b10);
        chk("t3_err", err, 1'b0);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("t3_noacc", wr_n - wb, 0);

        // MISO stuck low, three words
        rb = rx_n; ab = ack_n; sb = sso_tx_n;
        miso0 = 1'b1; tx_data0 = 16'h1234; req_len0 = 8'd3; req = 2'b01;
        wait_done(1000, d, e, c); req = 2'b00;
        miso0 = 1'b0;
        chk("t4_done", {d, e}, {2'b01, 1'b0});
        @(negedge clk);
        chk("t4_nack", ack_n - ab, 3);
        chk("t4_nrx", rx_n - rb, 3);
        chk("t4_sso_low", sso_tx_n - sb, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t4_rx%0d", i), rx_log[(rb + i) % 256], 16'h0000);

        // RRDY never arrives: timeout abort
        rb = rx_n; ab = ack_n;
        rrdy_block = 1'b1; req_len0 = 8'd2; req = 2'b01;
        wait_done(6000, d, e, c); req = 2'b00;
        rrdy_block = 1'b0;
        chk("t5_done", {d, e}, {2'b01, 1'b1});
        @(negedge clk);
        chk("t5_nack", ack_n - ab, 1);
        chk("t5_nrx", rx_n - rb, 0);
        chk("t5_latency", c - ack_cyc, 4101);
        chk("t5_last_acc", acc_log[(wr_n - 1) % 256], {1'b0, 3'd3, 16'h0000});

        // async reset during WAIT_R, then a clean burst
        tx_data0 = 16'h5A5A; req_len0 = 8'd3; req = 2'b01;
        for (int i = 0; i < 200 && tx_ack == 2'b00; i++) @(negedge clk);
        chk("t6_ack_seen", tx_ack, 2'b01);
        repeat (5) @(negedge clk);
        chk("t6_busy", grant, 2'b01);
        #2 reset_n = 1'b0; req = 2'b00;
        #1;
        chk("t6_rst_outs", {grant, tx_ack, rx_valid, done, err, spi_select, spi_read_n, spi_write_n},
            {8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
        chk("t6_rst_bus", {spi_addr, spi_wdata, rx_data}, 35'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rb = rx_n;
        tx_data1 = 16'hBEEF; req_len1 = 8'd1; req = 2'b10;
        wait_done(400, d, e, c); req = 2'b00;
        chk("t6_done", {d, e}, {2'b10, 1'b0});
        @(negedge clk);
        chk("t6_rx", {rx_n - rb, rx_log[rb % 256]}, {32'd1, 16'hBEEF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
